// File: rtl/ultrasonido_emulador.sv
// ultrasonido_emulador
//   Emulates the responder side of an HC-SR04 style ultrasonic sensor.
//   A trigger pulse from the controller is qualified by width. After a fixed
//   burst delay, an ECHO pulse is returned whose width encodes a programmed
//   distance in centimetres.
//
// Ports
//   clk       in   1  system clock
//   reset     in   1  asynchronous reset, active low
//   trigg     in   1  trigger from controller (asynchronous, synchronised here)
//   dist_cm   in   9  distance to emulate in cm, sampled when a valid trigger falls
//   ECHO      out  1  echo pulse to the controller (registered)
//   busy      out  1  high whenever the FSM is outside IDLE
//   trig_err  out  1  one-cycle pulse when a too-short trigger is rejected
module ultrasonido_emulador #(
    parameter int unsigned TICKS_PER_US  = 50,
    parameter int unsigned TRIG_MIN_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 200,
    parameter int unsigned US_PER_CM     = 58,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned TIMEOUT_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigg,
    input  logic [8:0] dist_cm,
    output logic       ECHO,
    output logic       busy,
    output logic       trig_err
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        DELAY,
        ECHO_HI,
        HOLDOFF
    } state_t;

    localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_US - 1);
    // Timebase value representing "one clk already elapsed": used when a state
    // is entered one cycle late (the cycle spent seeing the trigger edge).
    localparam logic [PW-1:0] PRE_ONE  = (TICKS_PER_US > 1) ? PW'(1) : '0;
    localparam logic [15:0]   US_ONE   = (TICKS_PER_US > 1) ? 16'd0 : 16'd1;

    localparam logic [15:0] TRIG_MIN   = 16'(TRIG_MIN_US);
    localparam logic [15:0] DELAY_LAST = 16'(ECHO_DELAY_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] MAX_D      = 16'(MAX_CM);
    localparam logic [15:0] CM_US      = 16'(US_PER_CM);
    localparam logic [15:0] TMO_US     = 16'(TIMEOUT_US);

    state_t        state;
    logic          s1, s2, s2_d;
    logic [PW-1:0] pre;
    logic [15:0]   us;
    logic [8:0]    dist_q;

    logic          pre_wrap;
    logic [15:0]   dist_ext;
    logic          in_range;
    logic [15:0]   echo_us;
    logic [15:0]   last_us;
    logic          done;

    always_comb begin
        pre_wrap = (pre == PRE_LAST);
        dist_ext = {7'd0, dist_q};
        in_range = (dist_q != '0) && (dist_ext <= MAX_D);
        echo_us  = in_range ? dist_ext * CM_US : TMO_US;
        case (state)
            DELAY:   last_us = DELAY_LAST;
            ECHO_HI: last_us = echo_us - 16'd1;
            default: last_us = HOLD_LAST;
        endcase
        done = pre_wrap && (us == last_us);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s2_d     <= 1'b0;
            pre      <= '0;
            us       <= '0;
            dist_q   <= '0;
            ECHO     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            s1       <= trigg;
            s2       <= s1;
            s2_d     <= s2;
            trig_err <= 1'b0;

            // Free-running us timebase; each state overrides it on entry.
            // The us count saturates so an over-long trigger stays valid.
            if (pre_wrap) begin
                pre <= '0;
                if (us != '1) us <= us + 16'd1;
            end else begin
                pre <= pre + PW'(1);
            end

            case (state)
                IDLE: begin
                    pre <= '0;
                    us  <= '0;
                    // Edge detect: a trigger held high into IDLE is ignored.
                    if (s2 && !s2_d) begin
                        // The detecting sample is itself one high clk.
                        state <= TRIG_HI;
                        busy  <= 1'b1;
                        pre   <= PRE_ONE;
                        us    <= US_ONE;
                    end
                end
                TRIG_HI: begin
                    if (!s2) begin
                        if (us >= TRIG_MIN) begin
                            dist_q <= dist_cm;
                            state  <= DELAY;
                            // Fall detection costs one clk of the burst
                            // delay, keeping ECHO at 2+delay after raw fall.
                            pre    <= PRE_ONE;
                            us     <= US_ONE;
                        end else begin
                            trig_err <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            pre      <= '0;
                            us       <= '0;
                        end
                    end
                end
                DELAY: begin
                    if (done) begin
                        state <= ECHO_HI;
                        ECHO  <= 1'b1;
                        pre   <= '0;
                        us    <= '0;
                    end
                end
                ECHO_HI: begin
                    if (done) begin
                        state <= HOLDOFF;
                        ECHO  <= 1'b0;
                        pre   <= '0;
                        us    <= '0;
                    end
                end
                HOLDOFF: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pre   <= '0;
                        us    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ECHO  <= 1'b0;
                    pre   <= '0;
                    us    <= '0;
                end
            endcase
        end
    end

endmodule
